// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encodings, NOP word, reset PC default
// and the IF/ID payload record.
package fetch_stage_pkg;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
   } ifid_word_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; PC+8 derived
// combinationally so it always tracks the registered PC.
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic        iclk,
   input  logic        irst_n,
   input  logic        i_load,
   input  logic        i_bubble,
   input  ifid_word_t  i_data,
   output logic [31:0] o_ir,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc8,
   output logic        o_valid
);
   logic [31:0] r_ir;
   logic [31:0] r_pc;
   logic        r_valid;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_ir    <= NOP_WORD;
         r_pc    <= 32'h0;
         r_valid <= 1'b0;
      end else if (i_bubble) begin
         // bubble keeps the last PC; only the word and valid are cleared
         r_ir    <= NOP_WORD;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_ir    <= i_data.ir;
         r_pc    <= i_data.pc;
         r_valid <= 1'b1;
      end
   end

   assign o_ir    = r_ir;
   assign o_pc    = r_pc;
   assign o_pc8   = r_pc + 32'd8;
   assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues fetches at pc, parks a stalled return in a
// one-entry buffer, and drains a redirected in-flight request in DROP.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        iclk,
   input  logic        irst_n,
   input  logic [31:0] inpc,
   input  logic        istall,
   input  logic        iflush,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        omem_req,
   output logic [31:0] omem_addr,
   output logic [31:0] oPC,
   output logic [31:0] oIR_D,
   output logic [31:0] oPC_D,
   output logic [31:0] oPC8_D,
   output logic        ovalid_D
);
   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_redir, w_redir_nxt;
   ifid_word_t   r_buf, w_buf_nxt;
   logic         r_buf_v, w_buf_v_nxt;
   logic         w_load, w_bubble;
   ifid_word_t   w_ifid_in;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_state <= ST_REQ;
         r_pc    <= RESET_PC;
         r_redir <= 32'h0;
         r_buf   <= '0;
         r_buf_v <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_redir <= w_redir_nxt;
         r_buf   <= w_buf_nxt;
         r_buf_v <= w_buf_v_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_redir_nxt = r_redir;
      w_buf_nxt   = r_buf;
      w_buf_v_nxt = r_buf_v;
      w_load      = 1'b0;
      w_bubble    = 1'b0;
      w_ifid_in   = '{ir: imem_rdata, pc: r_pc};
      unique case (r_state)
         ST_REQ: begin
            if (iflush) begin
               w_bubble = 1'b1;
               if (imem_ready) begin
                  w_pc_nxt = inpc;
               end else begin
                  // request still outstanding: keep address, remember target
                  w_redir_nxt = inpc;
                  w_state_nxt = ST_DROP;
               end
            end else if (imem_ready && !istall) begin
               w_load   = 1'b1;
               w_pc_nxt = inpc;
            end else if (imem_ready) begin
               w_buf_nxt   = '{ir: imem_rdata, pc: r_pc};
               w_buf_v_nxt = 1'b1;
               w_state_nxt = ST_HOLD;
            end else if (!istall) begin
               w_bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            if (iflush) begin
               w_bubble    = 1'b1;
               w_buf_v_nxt = 1'b0;
               w_pc_nxt    = inpc;
               w_state_nxt = ST_REQ;
            end else if (!istall) begin
               w_load      = r_buf_v;
               w_bubble    = !r_buf_v;
               w_ifid_in   = r_buf;
               w_buf_v_nxt = 1'b0;
               w_pc_nxt    = inpc;
               w_state_nxt = ST_REQ;
            end
         end
         ST_DROP: begin
            w_bubble = iflush || !istall;
            if (iflush) w_redir_nxt = inpc;
            if (imem_ready) begin
               // a same-cycle flush is the newest redirect target
               w_pc_nxt    = iflush ? inpc : r_redir;
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_REQ;
      endcase
   end

   if_id_reg u_if_id (
      .iclk     (iclk),
      .irst_n   (irst_n),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_data   (w_ifid_in),
      .o_ir     (oIR_D),
      .o_pc     (oPC_D),
      .o_pc8    (oPC8_D),
      .o_valid  (ovalid_D)
   );

   assign omem_req  = (r_state != ST_HOLD);
   assign omem_addr = r_pc;
   assign oPC       = r_pc;
endmodule
